adaptive_thresh_reader: RTL and testbench
=========================================

ADAPTIVE_THRESH_READER -- requirements
Module: adaptive_thresh_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per row (power of two, 8..256).
REQ-002 SHALL have parameter IMG_H, default 256, rows per frame; IMG_W*IMG_H SHALL NOT exceed 65536.
REQ-003 SHALL have parameter OFFSET, default 7, threshold offset C in grey levels (0..31).
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a frame pass when idle.
REQ-007 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last output pixel.
REQ-009 SHALL have port rdaddress  output  16  read address to middle_ram.
REQ-010 SHALL have port q  input  8  middle_ram read data, valid one clock after rdaddress.
REQ-011 SHALL have port out_valid  output  1  qualifies out_bit/out_x/out_y.
REQ-012 SHALL have port out_bit  output  1  1 = white (pixel at/above local mean minus C), 0 = black.
REQ-013 SHALL have ports out_x, out_y  output  8 each  coordinates of the current output pixel.

Function
REQ-014 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: start=1 SHALL move to READ with x=0, y=0; start SHALL be ignored outside IDLE.
REQ-016 READ: rdaddress SHALL equal y*IMG_W+x each cycle, x incrementing by 1, wrapping to 0 with y+1 at x=IMG_W-1.
REQ-017 READ SHALL exit to DRAIN after issuing address IMG_W*IMG_H-1 (no wrap past final address).
REQ-018 DRAIN SHALL last exactly 2 cycles to flush read latency and output register, then DONE.
REQ-019 DONE SHALL assert done for one cycle and return to IDLE; busy SHALL be high in READ and DRAIN only.
REQ-020 Throughput SHALL be one pixel per clock; out_valid for address A SHALL rise exactly 2 cycles after A appears on rdaddress.
REQ-021 SHALL keep an 8-tap window of the current row's last 8 pixels (including current) and an 11-bit running sum.
REQ-022 At x=0 all 8 taps SHALL load the row's first pixel p0 and sum SHALL load 8*p0 (edge replication); no carry-over between rows.
REQ-023 For x>0 sum SHALL update as sum + p_new - p_oldest in the same cycle the tap shifts.
REQ-024 out_bit SHALL be 1 iff 8*p + 8*OFFSET >= sum, evaluated in 12-bit unsigned arithmetic (no truncation).
REQ-025 out_x/out_y SHALL be the coordinates of the pixel read 2 cycles earlier; out_bit/out_x/out_y SHALL hold last value when out_valid=0.
REQ-026 Exactly IMG_W*IMG_H out_valid cycles SHALL occur per pass; done SHALL follow the last one by 1 cycle.
REQ-027 start coincident with done SHALL be ignored (FSM not yet IDLE).

Reset
REQ-028 reset_n low SHALL immediately force IDLE; busy, done, out_valid, out_bit=0; rdaddress, out_x, out_y, x, y, sum, taps=0.
REQ-029 Reset asserted mid-pass SHALL abort the pass with no done pulse; next start after release SHALL begin at address 0.

Structure
REQ-030 State encoding and window depth (8, log2 3) SHALL live in the shared project package; IMG_W/IMG_H/OFFSET remain module parameters.
REQ-031 Window taps and running sum SHALL be one sub-module, row_window_sum (inputs pixel, valid, row_start; output sum).

Verification
REQ-032 Bench SHALL instantiate middle_ram preloaded with data, IMG_W=8, IMG_H=2, OFFSET=7.
REQ-033 Flat row all 100 -> sum 800, every out_bit=1; 16 out_valid cycles; done 1 cycle after last.
REQ-034 Row0 = 0,0,0,0,0,0,0,200 -> pixel x=7: sum 200, out_bit=1; then row1 all 10 -> x=0 sum 80 (no carry-over), out_bit=1.
REQ-035 Row = 200x7 then 0 at x=7 -> sum 1400, 8*0+56=56 < 1400 -> out_bit=0 at (7,y).
REQ-036 Timing: start at cycle T -> rdaddress=0 at T+1, first out_valid at T+3, busy low and done high at T+19.
REQ-037 reset_n pulsed low at pixel 5 -> outputs zero immediately, no done; restart yields full 16 outputs from address 0.

Source files
------------

// File: rtl/adaptive_thresh_reader_pkg.sv
// Shared definitions for the adaptive threshold frame reader: FSM encoding,
// sliding-window geometry and the threshold compare.
package adaptive_thresh_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int WIN_DEPTH = 8;
    localparam int WIN_LOG2  = 3;
    localparam int PIX_W     = 8;
    localparam int SUM_W     = PIX_W + WIN_LOG2;
    localparam int CMP_W     = SUM_W + 1;

    // Coordinates travelling alongside a read through the RAM latency.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pix_meta_t;

    // White when 8*p + 8*off >= window sum; one guard bit so nothing truncates.
    function automatic logic thresh_white(input logic [PIX_W-1:0] p,
                                          input logic [SUM_W-1:0] sum,
                                          input logic [4:0]       off);
        logic [CMP_W-1:0] lhs;
        lhs = (CMP_W'(p) << WIN_LOG2) + (CMP_W'(off) << WIN_LOG2);
        return lhs >= CMP_W'(sum);
    endfunction

endpackage

// File: rtl/adaptive_thresh_reader_row_window_sum.sv
// Eight-tap per-row sliding window with a running sum. The sum output already
// includes the presented pixel so the caller can threshold in the same cycle.
module row_window_sum
    import adaptive_thresh_reader_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] pixel,
    input  logic             valid,
    input  logic             row_start,
    output logic [SUM_W-1:0] sum
);

    logic [WIN_DEPTH-1:0][PIX_W-1:0] taps;
    logic [SUM_W-1:0]                sum_q;

    // The oldest tap is always part of sum_q, so the subtraction never underflows.
    always_comb begin
        sum = sum_q + SUM_W'(pixel) - SUM_W'(taps[WIN_DEPTH-1]);
        if (row_start)
            sum = SUM_W'(pixel) << WIN_LOG2;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taps[0] <= '0;
            sum_q   <= '0;
        end else if (valid) begin
            taps[0] <= pixel;
            sum_q   <= sum;
        end
    end

    // Row start replicates the first pixel into every tap so the left edge
    // sees a full window and nothing leaks from the previous row.
    for (genvar i = 1; i < WIN_DEPTH; i++) begin : g_tap
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                taps[i] <= '0;
            else if (valid)
                taps[i] <= row_start ? pixel : taps[i-1];
        end
    end

endmodule

// File: rtl/adaptive_thresh_reader.sv
// Raster-scans a frame out of middle_ram and emits one adaptive-threshold bit
// per pixel, two cycles behind its read address.
module adaptive_thresh_reader
    import adaptive_thresh_reader_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int OFFSET = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdaddress,
    input  logic [7:0]  q,
    output logic        out_valid,
    output logic        out_bit,
    output logic [7:0]  out_x,
    output logic [7:0]  out_y
);

    localparam logic [15:0] LAST_ADDR = 16'(IMG_W * IMG_H - 1);
    localparam logic [7:0]  X_LAST    = 8'(IMG_W - 1);

    state_t           state;
    logic [7:0]       x, y;
    logic             drain_cnt;
    logic [2:1]       vld_pipe;
    pix_meta_t        meta_d1;
    logic [SUM_W-1:0] win_sum;

    assign out_valid = vld_pipe[2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdaddress <= '0;
            x         <= '0;
            y         <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_READ;
                        busy      <= 1'b1;
                        rdaddress <= '0;
                        x         <= '0;
                        y         <= '0;
                    end
                end
                ST_READ: begin
                    if (rdaddress == LAST_ADDR) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        rdaddress <= rdaddress + 16'd1;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 8'd1;
                        end else begin
                            x <= x + 8'd1;
                        end
                    end
                end
                // One cycle for RAM latency, one for the output register.
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1 lines up with q; stage 2 is the registered output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            meta_d1  <= '0;
        end else begin
            vld_pipe[1] <= (state == ST_READ);
            vld_pipe[2] <= vld_pipe[1];
            meta_d1     <= '{x: x, y: y};
        end
    end

    row_window_sum u_win (
        .clock     (clock),
        .reset_n   (reset_n),
        .pixel     (q),
        .valid     (vld_pipe[1]),
        .row_start (meta_d1.x == 8'd0),
        .sum       (win_sum)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_bit <= 1'b0;
            out_x   <= '0;
            out_y   <= '0;
        end else if (vld_pipe[1]) begin
            out_bit <= thresh_white(q, win_sum, 5'(OFFSET));
            out_x   <= meta_d1.x;
            out_y   <= meta_d1.y;
        end
    end

endmodule

// File: tb/tb_adaptive_thresh_reader.sv
// Scoreboard bench: 8x2 frames with hand-derived white/black masks, timing,
// start-during-done and mid-pass reset abort.
module tb_adaptive_thresh_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, out_valid, out_bit;
    logic [15:0] rdaddress;
    logic [7:0]  q = 8'd0;
    logic [7:0]  out_x, out_y;

    logic [7:0]  mem [16];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   vcnt   = 0;
    int   dcnt   = 0;

    always #5 clock = ~clock;

    // middle_ram: one-cycle registered read
    always @(posedge clock) q <= mem[rdaddress[3:0]];

    adaptive_thresh_reader #(.IMG_W(8), .IMG_H(2), .OFFSET(7)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rdaddress (rdaddress),
        .q         (q),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: pops one expectation per out_valid cycle.
    always @(negedge clock) begin
        if (out_valid) begin
            vcnt++;
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_x", int'(out_x), int'(e.x));
                chk("out_y", int'(out_y), int'(e.y));
                chk($sformatf("out_bit(%0d,%0d)", e.x, e.y), int'(out_bit), int'(e.b));
            end
        end
        if (done) dcnt++;
    end

    task automatic load(input logic [63:0] r0, input logic [63:0] r1);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = r0[i*8 +: 8];
            mem[8 + i] = r1[i*8 +: 8];
        end
    endtask

    task automatic push(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.x = 8'(i % 8);
            e.y = 8'(i / 8);
            e.b = mask[i];
            sb.push_back(e);
        end
    endtask

    // Full pass: start accepted at edge T, checks sampled on negedges.
    task automatic run_pass(input string nm, input logic [15:0] mask);
        int v0, d0;
        v0 = vcnt;
        d0 = dcnt;
        push(mask, 16);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;                 // T+1
        chk({nm, ":busy@T+1"}, int'(busy), 1);
        chk({nm, ":addr@T+1"}, int'(rdaddress), 0);
        chk({nm, ":valid@T+1"}, int'(out_valid), 0);
        @(negedge clock);                              // T+2
        chk({nm, ":valid@T+2"}, int'(out_valid), 0);
        @(negedge clock);                              // T+3
        chk({nm, ":valid@T+3"}, int'(out_valid), 1);
        @(negedge clock); @(negedge clock);            // T+5
        chk({nm, ":addr@T+5"}, int'(rdaddress), 4);
        repeat (13) @(negedge clock);                  // T+18
        chk({nm, ":busy@T+18"}, int'(busy), 1);
        chk({nm, ":done@T+18"}, int'(done), 0);
        @(negedge clock);                              // T+19
        chk({nm, ":busy@T+19"}, int'(busy), 0);
        chk({nm, ":done@T+19"}, int'(done), 1);
        start = 1'b1;                                  // coincident with done
        @(negedge clock) start = 1'b0;                 // T+20
        chk({nm, ":done@T+20"}, int'(done), 0);
        @(negedge clock);                              // T+21
        chk({nm, ":start_during_done_ignored"}, int'(busy), 0);
        chk({nm, ":valid_count"}, vcnt - v0, 16);
        chk({nm, ":done_count"}, dcnt - d0, 1);
        chk({nm, ":scoreboard_empty"}, sb.size(), 0);
    endtask

    initial begin
        int v0, d0;
        load(64'h0, 64'h0);
        #1;
        chk("rst:busy", int'(busy), 0);
        chk("rst:done", int'(done), 0);
        chk("rst:valid", int'(out_valid), 0);
        chk("rst:addr", int'(rdaddress), 0);
        chk("rst:out_x", int'(out_x), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Flat 100: sum 800, all white
        load(64'h6464646464646464, 64'h6464646464646464);
        run_pass("flat100", 16'hFFFF);

        // Lone 200 at x=7, then row of 10 (x=0 sum 80 only if no carry-over)
        load(64'hC800000000000000, 64'h0A0A0A0A0A0A0A0A);
        run_pass("edge200", 16'hFFFF);

        // 200x7 then 0: (7,0) black; row1 50x4,10x4: x=4..7 black
        load(64'h00C8C8C8C8C8C8C8, 64'h0A0A0A0A32323232);
        run_pass("dropoff", 16'h0F7F);

        // Equality boundary: 20,12 -> 152>=152 white; 20,11 -> 144<151 black
        load(64'h0C0C0C0C0C0C0C14, 64'h0B0B0B0B0B0B0B14);
        run_pass("boundary", 16'hFDFF);

        // All 255: 8*255+56 exceeds 11 bits
        load(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        run_pass("sat255", 16'hFFFF);

        // Abort at pixel 5: pixels 0..3 emerge before reset
        load(64'h00C8C8C8C8C8C8C8, 64'h0A0A0A0A32323232);
        v0 = vcnt;
        d0 = dcnt;
        push(16'h0F7F, 4);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;                 // T+1
        repeat (5) @(negedge clock);                   // T+6
        chk("abort:addr_at_reset", int'(rdaddress), 5);
        #1 reset_n = 1'b0;
        #1;
        chk("abort:busy", int'(busy), 0);
        chk("abort:valid", int'(out_valid), 0);
        chk("abort:out_bit", int'(out_bit), 0);
        chk("abort:out_x", int'(out_x), 0);
        chk("abort:out_y", int'(out_y), 0);
        chk("abort:addr", int'(rdaddress), 0);
        @(negedge clock) reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("abort:no_done", dcnt - d0, 0);
        chk("abort:valid_count", vcnt - v0, 4);
        chk("abort:busy_after", int'(busy), 0);
        chk("abort:scoreboard_empty", sb.size(), 0);

        run_pass("restart", 16'h0F7F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
